// File: rtl/spi_pkg.sv
// Shared types and helpers for the generic SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } state_t;

  // SPI mode numbers as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timing: half-period down-counter and edge counter for one transfer.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_lead_pulse,
  output logic             o_trail_pulse,
  output logic             o_last_edge,
  output logic             o_phase_end
);

  localparam int unsigned EDGE_W = $clog2(2 * DATA_W) + 1;
  localparam logic [EDGE_W-1:0] NUM_EDGES = EDGE_W'(2 * DATA_W);

  logic [DIV_W-1:0]  r_cnt;
  logic [EDGE_W-1:0] r_edge;
  logic              w_edge_ok;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt  <= '0;
      r_edge <= '0;
    end else if (i_clear) begin
      r_cnt  <= i_div;
      r_edge <= '0;
    end else if (i_run) begin
      if (r_cnt == '0) begin
        r_cnt <= i_div;
        if (w_edge_ok) r_edge <= r_edge + 1'b1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Even edge count means the next SCLK edge is a leading one
  always_comb begin
    o_phase_end   = i_run && (r_cnt == '0);
    w_edge_ok     = (r_edge < NUM_EDGES);
    o_lead_pulse  = o_phase_end && w_edge_ok && !r_edge[0];
    o_trail_pulse = o_phase_end && w_edge_ok && r_edge[0];
    o_last_edge   = o_trail_pulse && (r_edge == NUM_EDGES - 1'b1);
  end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: all four modes, runtime divider, MSB/LSB order, one-hot-low selects.
module spi_master_gen
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CS = 4,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned CS_W   = clog2_min1(NUM_CS)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  input  logic [DIV_W-1:0]  i_clk_div,
  input  logic [CS_W-1:0]   i_cs_sel,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_miso,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic [NUM_CS-1:0] o_cs_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned CS_SPAN = 1 << CS_W;

  state_t            r_state, w_state_nxt;
  logic              r_cpol, r_cpha, r_lsb;
  logic [DIV_W-1:0]  r_div;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic              r_sclk, r_mosi, r_busy, r_done, r_err;
  logic [NUM_CS-1:0] r_cs_n;

  logic              w_accept, w_reject, w_run, w_sample_lead;
  logic              w_lead, w_trail, w_last, w_phase_end;
  logic [DIV_W-1:0]  w_div;
  logic [NUM_CS-1:0] w_cs_dec;
  logic [CS_SPAN-1:0] w_cs_valid;

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b,
                                                input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  // Table lookup instead of a compare so power-of-two NUM_CS stays warning-free
  always_comb begin
    w_cs_valid = '0;
    for (int unsigned i = 0; i < CS_SPAN; i++) w_cs_valid[i] = (i < NUM_CS);
    w_cs_dec = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) w_cs_dec[i] = (i_cs_sel == CS_W'(i));
  end

  always_comb begin
    w_accept = (r_state == IDLE) && i_start && w_cs_valid[i_cs_sel];
    w_reject = (r_state == IDLE) && i_start && !w_cs_valid[i_cs_sel];
    w_run    = (r_state == SETUP) || (r_state == XFER) || (r_state == HOLD);
    w_div    = w_accept ? i_clk_div : r_div;
    w_sample_lead = 1'b0;
    unique case ({r_cpol, r_cpha})
      MODE0, MODE2: w_sample_lead = 1'b1;
      MODE1, MODE3: w_sample_lead = 1'b0;
      default:      w_sample_lead = 1'b0;
    endcase
  end

  spi_sclk_gen #(
    .DATA_W(DATA_W),
    .DIV_W (DIV_W)
  ) u_sclk_gen (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (w_accept),
    .i_run        (w_run),
    .i_div        (w_div),
    .o_lead_pulse (w_lead),
    .o_trail_pulse(w_trail),
    .o_last_edge  (w_last),
    .o_phase_end  (w_phase_end)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SETUP;
      SETUP:   if (w_lead) w_state_nxt = XFER;
      XFER:    if (w_last) w_state_nxt = HOLD;
      HOLD:    if (w_phase_end) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_lsb     <= 1'b0;
      r_div     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_reject;
      case (r_state)
        IDLE: begin
          r_sclk <= i_cpol;
          r_mosi <= 1'b0;
          if (w_accept) begin
            r_cpol <= i_cpol;
            r_cpha <= i_cpha;
            r_lsb  <= i_lsb_first;
            r_div  <= i_clk_div;
            r_cs_n <= ~w_cs_dec;
            r_busy <= 1'b1;
            r_rx   <= '0;
            // cpha=0 needs the first bit on the line before the first leading edge
            if (!i_cpha) begin
              r_mosi <= first_bit(i_tx_data, i_lsb_first);
              r_tx   <= shift_out(i_tx_data, i_lsb_first);
            end else begin
              r_tx <= i_tx_data;
            end
          end
        end
        SETUP, XFER: begin
          if (w_lead || w_trail) r_sclk <= ~r_sclk;
          if ((w_lead && w_sample_lead) || (w_trail && !w_sample_lead)) begin
            r_rx <= shift_in(r_rx, i_miso, r_lsb);
          end
          if ((w_trail && w_sample_lead && !w_last) || (w_lead && !w_sample_lead)) begin
            r_mosi <= first_bit(r_tx, r_lsb);
            r_tx   <= shift_out(r_tx, r_lsb);
          end
        end
        HOLD: begin
          if (w_phase_end) begin
            r_cs_n    <= '1;
            r_done    <= 1'b1;
            r_rx_data <= r_rx;
            r_mosi    <= 1'b0;
          end
        end
        DONE: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_rx_data = r_rx_data;
  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;
  assign o_cs_n    = r_cs_n;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;

endmodule

// File: tb/tb_spi_master_gen.sv
// Scoreboard bench for spi_master_gen: 8-bit/4-CS instance with a slave model, 16-bit/3-CS loopback.
module tb_spi_master_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // Instance A: DATA_W=8, NUM_CS=4
  logic       start, cpol, cpha, lsb, miso;
  logic [7:0] div, tx;
  logic [1:0] cs_sel;
  logic [7:0] rx;
  logic       sclk, mosi, busy, done, err;
  logic [3:0] cs_n;

  // Instance B: DATA_W=16, NUM_CS=3, loopback
  logic        start_b, cpol_b, cpha_b, lsb_b;
  logic [3:0]  div_b;
  logic [1:0]  cs_sel_b;
  logic [15:0] tx_b, rx_b;
  logic        sclk_b, mosi_b, busy_b, done_b, err_b;
  logic [2:0]  cs_n_b;

  spi_master_gen #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_cpol(cpol), .i_cpha(cpha),
    .i_lsb_first(lsb), .i_clk_div(div), .i_cs_sel(cs_sel), .i_tx_data(tx), .i_miso(miso),
    .o_rx_data(rx), .o_sclk(sclk), .o_mosi(mosi), .o_cs_n(cs_n), .o_busy(busy),
    .o_done(done), .o_err(err)
  );

  spi_master_gen #(.DATA_W(16), .NUM_CS(3), .DIV_W(4)) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start_b), .i_cpol(cpol_b), .i_cpha(cpha_b),
    .i_lsb_first(lsb_b), .i_clk_div(div_b), .i_cs_sel(cs_sel_b), .i_tx_data(tx_b),
    .i_miso(mosi_b), .o_rx_data(rx_b), .o_sclk(sclk_b), .o_mosi(mosi_b), .o_cs_n(cs_n_b),
    .o_busy(busy_b), .o_done(done_b), .o_err(err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] rx;
    logic [31:0] tx;
    int          acc;
    int          lat;
    logic [3:0]  cs;
  } exp_t;

  exp_t sb[$];
  exp_t sbb[$];

  // Slave model state (instance A)
  logic [7:0] g_word;
  logic [7:0] s_word, s_mosi_w;
  logic       s_cpha, s_lsb, s_sel, s_sel_prev, s_sclk_prev, s_cs_stable, s_lead;
  logic [3:0] s_cs_seen;
  int         s_bit, s_mi, s_edges, s_fall_cyc;

  function automatic logic sbit(input logic [7:0] w, input logic l, input int i);
    return l ? w[i] : w[7-i];
  endfunction

  // Slave drives miso / captures mosi from observed SCLK edges, then the monitor checks done
  always @(negedge clk) begin
    if (!rst_n) begin
      s_sel_prev  = 1'b0;
      s_sclk_prev = sclk;
      miso        = 1'b0;
    end else begin
      s_sel = (cs_n != 4'hF);
      if (s_sel && !s_sel_prev) begin
        s_fall_cyc  = cyc;
        s_cs_seen   = cs_n;
        s_cs_stable = 1'b1;
        s_bit = 0; s_mi = 0; s_edges = 0;
        s_mosi_w = 8'h00;
        s_cpha = cpha; s_lsb = lsb; s_word = g_word;
        if (!cpha) begin
          miso  = sbit(g_word, lsb, 0);
          s_bit = 1;
        end
      end else if (s_sel) begin
        if (cs_n != s_cs_seen) s_cs_stable = 1'b0;
        if (sclk != s_sclk_prev) begin
          s_edges++;
          s_lead = s_edges[0];
          if (s_lead == !s_cpha) begin
            if (s_mi < 8) begin
              if (s_lsb) s_mosi_w[s_mi] = mosi;
              else       s_mosi_w[7-s_mi] = mosi;
              s_mi++;
            end
          end else if (s_bit < 8) begin
            miso = sbit(s_word, s_lsb, s_bit);
            s_bit++;
          end
        end
      end
      s_sel_prev  = s_sel;
      s_sclk_prev = sclk;

      if (done) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("rx_data", rx, e.rx);
          check("mosi_word", s_mosi_w, e.tx);
          check("done_latency", cyc - e.acc, e.lat);
          check("cs_fall_cycle", s_fall_cyc, e.acc);
          check("cs_n_during", s_cs_seen, e.cs);
          check("cs_n_stable", s_cs_stable, 1);
          check("sclk_edges", s_edges, 16);
          check("cs_n_at_done", cs_n, 4'hF);
          check("busy_at_done", busy, 1);
        end
      end
      if (err) check("err_a_spurious", err, 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && done_b) begin
      check("sbb_nonempty", sbb.size() != 0, 1);
      if (sbb.size() != 0) begin
        exp_t e;
        e = sbb.pop_front();
        check("rx_b_loopback", rx_b, e.rx);
        check("done_latency_b", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic wait_idle_a();
    int n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Issue one transfer on A; pulse_at>0 adds an ignored start that many cycles in
  task automatic run_a(input logic pl, input logic ph, input logic l, input logic [7:0] d,
                       input logic [1:0] cs, input logic [7:0] t, input logic [7:0] w,
                       input int pulse_at);
    exp_t e;
    @(negedge clk);
    wait_idle_a();
    cpol = pl; cpha = ph; lsb = l; div = d; cs_sel = cs; tx = t; g_word = w;
    start = 1'b1;
    e.rx = {24'h0, w}; e.tx = {24'h0, t}; e.acc = cyc + 1;
    e.lat = 17 * (int'(d) + 1); e.cs = ~(4'b0001 << cs);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (pulse_at > 0) begin
      repeat (pulse_at - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("sclk_idle_level", sclk, cpol);
    check("busy_idle", busy, 0);
  endtask

  task automatic run_b(input logic [15:0] t, input logic [3:0] d, input logic pl,
                       input logic ph, input logic l, input logic [1:0] cs);
    exp_t e;
    int n = 0;
    @(negedge clk);
    cpol_b = pl; cpha_b = ph; lsb_b = l; div_b = d; cs_sel_b = cs; tx_b = t;
    start_b = 1'b1;
    e.rx = {16'h0, t}; e.tx = {16'h0, t}; e.acc = cyc + 1;
    e.lat = 33 * (int'(d) + 1); e.cs = 4'h0;
    sbb.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    while (sbb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen_b", sbb.size(), 0);
    sbb.delete();
    repeat (2) @(negedge clk);
    check("sclk_b_idle", sclk_b, cpol_b);
  endtask

  initial begin
    exp_t e1, e2;
    int   n;
    rst_n = 1'b0;
    start = 0; cpol = 0; cpha = 0; lsb = 0; div = 0; cs_sel = 0; tx = 0; g_word = 0;
    start_b = 0; cpol_b = 0; cpha_b = 0; lsb_b = 0; div_b = 0; cs_sel_b = 0; tx_b = 0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rx", rx, 0);
    check("rst_cs_n_b", cs_n_b, 3'h7);
    rst_n = 1'b1;

    run_a(0, 0, 0, 8'd0, 2'd0, 8'hA5, 8'h3C, 0);   wait_done_a();
    run_a(1, 1, 0, 8'd3, 2'd2, 8'h81, 8'hF0, 0);   wait_done_a();
    run_a(0, 1, 1, 8'd1, 2'd1, 8'h01, 8'h80, 0);   wait_done_a();
    run_a(0, 0, 0, 8'd0, 2'd3, 8'hC3, 8'h5A, 5);   wait_done_a();
    run_a(1, 0, 1, 8'd255, 2'd1, 8'h6E, 8'h93, 0); wait_done_a();

    // Async reset part-way through a transfer: no done, idle outputs at once
    run_a(0, 0, 0, 8'd0, 2'd1, 8'h96, 8'h69, 0);
    repeat (5) @(negedge clk);
    #2;
    void'(sb.pop_back());
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", cs_n, 4'hF);
    check("midrst_sclk", sclk, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rx", rx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_a(0, 0, 0, 8'd1, 2'd0, 8'h5A, 8'hA6, 0); wait_done_a();

    // Back-to-back with start held high across the first done
    @(negedge clk);
    cpol = 0; cpha = 1; lsb = 0; div = 8'd0; cs_sel = 2'd3; tx = 8'h3F; g_word = 8'hC1;
    start = 1'b1;
    e1.rx = 32'hC1; e1.tx = 32'h3F; e1.acc = cyc + 1; e1.lat = 17; e1.cs = 4'b0111;
    sb.push_back(e1);
    repeat (2) @(negedge clk);
    tx = 8'hE4; g_word = 8'h1B;
    e2.rx = 32'h1B; e2.tx = 32'hE4; e2.acc = e1.acc + 17 + 2; e2.lat = 17; e2.cs = 4'b0111;
    sb.push_back(e2);
    n = 0;
    while (cyc < e2.acc && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    wait_done_a();

    for (int i = 0; i < 16; i++) begin
      run_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom),
            8'($urandom), 0);
      wait_done_a();
    end

    // Invalid chip select on the 3-CS build is rejected with a one-cycle err
    @(negedge clk);
    cs_sel_b = 2'd3;
    start_b  = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("err_b_pulse", err_b, 1);
    check("err_b_cs_n", cs_n_b, 3'h7);
    check("err_b_busy", busy_b, 0);
    @(negedge clk);
    check("err_b_clear", err_b, 0);
    check("err_b_busy2", busy_b, 0);

    run_b(16'hBEEF, 4'd0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      run_b(16'($urandom), 4'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)));
    end

    check("sb_drained", sb.size() + sbb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
